// File: rtl/alu_flag_exec.sv
// alu_flag_exec: execute stage with ALU, NZCV flag register, condition squash and a one-entry output register.
// Optional EXEC_CNT_EN adds exec_count_o/squash_count_o accept counters.
module alu_flag_exec #(
    parameter int          WIDTH    = 32,
    parameter logic [3:0]  FLAG_RST = 4'b0000
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       alu_control_i,
    input  logic [1:0]       flag_w_i,
    input  logic             no_write_i,
    input  logic [3:0]       cond_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    input  logic             reg_write_in_i,
    input  logic             mem_write_in_i,
    input  logic             pc_src_in_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             reg_write_o,
    output logic             mem_write_o,
    output logic             pc_src_o,
    output logic             cond_ex_o,
`ifdef EXEC_CNT_EN
    output logic [15:0]      exec_count_o,
    output logic [15:0]      squash_count_o,
`endif
    output logic [3:0]       flags_o
);
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;

    logic             accept;
    logic             is_sub;
    logic             is_arith;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_r;
    logic             n_f, z_f, c_f, v_f;
    logic             cond_ok;
    logic             n_q, z_q, c_q, v_q;
    logic [3:0]       flags_q, flags_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q;
    logic             reg_write_q, mem_write_q, pc_src_q, cond_ex_q;

    assign in_ready_o = ~out_valid_q | out_ready_i;
    assign accept     = in_valid_i & in_ready_o;
    assign {n_q, z_q, c_q, v_q} = flags_q;

    // SUB shares the adder: a + ~b + 1, so carry out is the inverted borrow.
    always_comb begin
        is_sub   = alu_control_i == OP_SUB;
        is_arith = is_sub | (alu_control_i == OP_ADD);
        b_eff    = is_sub ? ~src_b_i : src_b_i;
        sum      = {1'b0, src_a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        alu_r    = is_arith ? sum[WIDTH-1:0] :
                   (alu_control_i == OP_AND) ? (src_a_i & src_b_i) : (src_a_i | src_b_i);
        n_f      = alu_r[WIDTH-1];
        z_f      = alu_r == '0;
        c_f      = is_arith & sum[WIDTH];
        v_f      = is_arith & (src_a_i[WIDTH-1] == b_eff[WIDTH-1]) & (alu_r[WIDTH-1] != src_a_i[WIDTH-1]);
    end

    always_comb begin
        cond_ok = 1'b0;
        case (cond_i)
            4'b0000: cond_ok = z_q;
            4'b0001: cond_ok = ~z_q;
            4'b0010: cond_ok = c_q;
            4'b0011: cond_ok = ~c_q;
            4'b0100: cond_ok = n_q;
            4'b0101: cond_ok = ~n_q;
            4'b0110: cond_ok = v_q;
            4'b0111: cond_ok = ~v_q;
            4'b1000: cond_ok = c_q & ~z_q;
            4'b1001: cond_ok = ~c_q | z_q;
            4'b1010: cond_ok = n_q == v_q;
            4'b1011: cond_ok = n_q != v_q;
            4'b1100: cond_ok = ~z_q & (n_q == v_q);
            4'b1101: cond_ok = z_q | (n_q != v_q);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    always_comb begin
        flags_d     = flags_q;
        flags_d[3:2] = (accept & cond_ok & flag_w_i[1]) ? {n_f, z_f} : flags_q[3:2];
        flags_d[1:0] = (accept & cond_ok & flag_w_i[0]) ? {c_f, v_f} : flags_q[1:0];
        out_valid_d = accept | (out_valid_q & ~out_ready_i);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            flags_q     <= FLAG_RST;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            reg_write_q <= 1'b0;
            mem_write_q <= 1'b0;
            pc_src_q    <= 1'b0;
            cond_ex_q   <= 1'b0;
        end else begin
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
            if (accept) begin
                result_q    <= alu_r;
                reg_write_q <= reg_write_in_i & cond_ok & ~no_write_i;
                mem_write_q <= mem_write_in_i & cond_ok;
                pc_src_q    <= pc_src_in_i & cond_ok;
                cond_ex_q   <= cond_ok;
            end
        end
    end

`ifdef EXEC_CNT_EN
    logic [15:0] exec_count_q, squash_count_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            exec_count_q   <= '0;
            squash_count_q <= '0;
        end else if (accept) begin
            exec_count_q   <= cond_ok ? exec_count_q + 16'd1 : exec_count_q;
            squash_count_q <= cond_ok ? squash_count_q : squash_count_q + 16'd1;
        end
    end

    assign exec_count_o   = exec_count_q;
    assign squash_count_o = squash_count_q;
`endif

    assign flags_o     = flags_q;
    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign reg_write_o = reg_write_q;
    assign mem_write_o = mem_write_q;
    assign pc_src_o    = pc_src_q;
    assign cond_ex_o   = cond_ex_q;
endmodule

// File: tb/tb_alu_flag_exec.sv
// tb_alu_flag_exec: directed vectors pushed to a scoreboard, popped by an output monitor.
module tb_alu_flag_exec;
    typedef struct packed {
        logic [31:0] r;
        logic [3:0]  c;
        logic [3:0]  fl;
    } exp_t;

    localparam logic [1:0] AND_ = 2'b00, ADD_ = 2'b01, SUB_ = 2'b10, ORR_ = 2'b11;

    logic        clk = 0, rst = 1;
    logic        in_valid = 0, in_ready, no_write = 0, out_valid, out_ready = 0;
    logic [1:0]  alu = 0, fw = 0;
    logic [3:0]  cond = 0, flags;
    logic [31:0] a = 0, b = 0, result;
    logic        rwi = 0, mwi = 0, pci = 0, reg_write, mem_write, pc_src, cond_ex;
`ifdef EXEC_CNT_EN
    logic [15:0] exec_count, squash_count;
`endif
    int total = 0, bad = 0;
    exp_t q[$];

    alu_flag_exec dut (
        .clk_i(clk), .reset_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .alu_control_i(alu), .flag_w_i(fw), .no_write_i(no_write), .cond_i(cond),
        .src_a_i(a), .src_b_i(b), .reg_write_in_i(rwi), .mem_write_in_i(mwi),
        .pc_src_in_i(pci), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .result_o(result), .reg_write_o(reg_write), .mem_write_o(mem_write),
        .pc_src_o(pc_src), .cond_ex_o(cond_ex),
`ifdef EXEC_CNT_EN
        .exec_count_o(exec_count), .squash_count_o(squash_count),
`endif
        .flags_o(flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ctl = {reg_write_in, mem_write_in, pc_src_in}; ectl = {reg_write, mem_write, pc_src, cond_ex}
    task automatic issue(input logic [1:0] op, input logic [1:0] f, input logic nw, input logic [3:0] cd,
                         input logic [31:0] sa, input logic [31:0] sb, input logic [2:0] ctl,
                         input logic [31:0] er, input logic [3:0] ectl, input logic [3:0] efl);
        bit acc = 0;
        alu = op; fw = f; no_write = nw; cond = cd; a = sa; b = sb;
        {rwi, mwi, pci} = ctl;
        in_valid = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back(exp_t'({er, ectl, efl}));
                acc = 1;
                break;
            end
        end
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got result %h want none", result);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("result", result, e.r);
                check("rw_mw_pc_cx", {28'd0, reg_write, mem_write, pc_src, cond_ex}, {28'd0, e.c});
                check("flags", {28'd0, flags}, {28'd0, e.fl});
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 0;
        // Asynchronous reset while an entry is held
        issue(SUB_, 2'b11, 0, 4'hE, 32'd5, 32'd5, 3'b100, 32'd0, 4'b1001, 4'b0110);
        @(negedge clk);
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        check("pre_rst_flags", {28'd0, flags}, 32'b0110);
        #2 rst = 1;
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_flags", {28'd0, flags}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_result", result, 32'd0);
        check("rst_ctl", {28'd0, reg_write, mem_write, pc_src, cond_ex}, 32'd0);
        q.delete();
        @(posedge clk);
        #1 rst = 0;
        out_ready = 1;
        issue(SUB_, 2'b11, 0, 4'hE, 32'd5, 32'd5, 3'b100, 32'd0, 4'b1001, 4'b0110);
        issue(ADD_, 2'b11, 0, 4'hE, 32'h7FFFFFFF, 32'd1, 3'b110, 32'h80000000, 4'b1101, 4'b1001);
        issue(SUB_, 2'b11, 0, 4'hE, 32'd5, 32'd5, 3'b000, 32'd0, 4'b0001, 4'b0110);
        issue(SUB_, 2'b11, 0, 4'h0, 32'd3, 32'd3, 3'b111, 32'd0, 4'b1111, 4'b0110);
        issue(ADD_, 2'b11, 0, 4'h1, 32'd1, 32'd1, 3'b111, 32'd2, 4'b0000, 4'b0110);
        issue(SUB_, 2'b11, 0, 4'hE, 32'h80000000, 32'd1, 3'b000, 32'h7FFFFFFF, 4'b0001, 4'b0011);
        issue(AND_, 2'b10, 0, 4'hE, 32'd0, 32'hF, 3'b100, 32'd0, 4'b1001, 4'b0111);
        issue(ORR_, 2'b00, 0, 4'hE, 32'hF0, 32'h0F, 3'b100, 32'hFF, 4'b1001, 4'b0111);
        issue(SUB_, 2'b11, 1, 4'hE, 32'd3, 32'd5, 3'b100, 32'hFFFFFFFE, 4'b0001, 4'b1000);
        issue(ADD_, 2'b11, 0, 4'hC, 32'd1, 32'd1, 3'b101, 32'd2, 4'b0000, 4'b1000);
        issue(ADD_, 2'b00, 0, 4'hB, 32'd2, 32'd3, 3'b010, 32'd5, 4'b0101, 4'b1000);
        issue(ORR_, 2'b11, 0, 4'hF, 32'd1, 32'd2, 3'b100, 32'd3, 4'b0000, 4'b1000);
        issue(ADD_, 2'b11, 0, 4'h8, 32'd1, 32'd1, 3'b100, 32'd2, 4'b0000, 4'b1000);
        issue(SUB_, 2'b11, 0, 4'h9, 32'd1, 32'd1, 3'b001, 32'd0, 4'b0011, 4'b0110);
        issue(ADD_, 2'b01, 0, 4'hA, 32'h7FFFFFFF, 32'd1, 3'b100, 32'h80000000, 4'b1001, 4'b0101);
        issue(AND_, 2'b00, 0, 4'h6, 32'hFF, 32'h0F, 3'b010, 32'h0F, 4'b0101, 4'b0101);
        issue(ADD_, 2'b11, 0, 4'h4, 32'd1, 32'd1, 3'b100, 32'd2, 4'b0000, 4'b0101);
        @(posedge clk);
        #1 out_ready = 0;
        // Backpressure: held entry must stay put while the next op waits
        issue(ADD_, 2'b00, 0, 4'hE, 32'h10, 32'h20, 3'b100, 32'h30, 4'b1001, 4'b0101);
        alu = SUB_; fw = 2'b11; cond = 4'hE; a = 32'h30; b = 32'h10; in_valid = 1;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_result", result, 32'h30);
            @(posedge clk);
            #1;
        end
        out_ready = 1;
        issue(SUB_, 2'b11, 0, 4'hE, 32'h30, 32'h10, 3'b100, 32'h20, 4'b1001, 4'b0010);
        @(negedge clk);
        check("no_bubble_valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        check("drain_left", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
